mips_cache_arbiter: RTL and testbench

Parametrised memory-side arbiter for the MIPS cache subsystem. Merges NUM_RD read-fill requesters (instruction cache, data cache, future prefetcher) and one write-buffer drain channel onto a single Avalon-MM master port. Adds:
- configurable read-port count and address/data width;
- write-buffer starvation protection and full-buffer priority boost;
- optional round-robin read arbitration.

---
 rtl/mips_cache_pkg.sv | 21 ++
 rtl/mips_arb_picker.sv | 49 ++++
 rtl/mips_cache_arbiter.sv | 136 +++++++++++++
 tb/tb_mips_cache_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cache_pkg.sv
// Shared types and default widths for the MIPS cache memory-side arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Optional round-robin read arbitration is selected with MIPS_ARB_ROUND_ROBIN_EN.
package mips_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    localparam int ARB_NUM_RD       = 2;
    localparam int ARB_ADDR_W       = 32;
    localparam int ARB_DATA_W       = 32;
    localparam int ARB_STARVE_LIMIT = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_arb_picker.sv
// Read-request picker: one-hot grant and index from a request vector (fixed priority, or round-robin under MIPS_ARB_ROUND_ROBIN_EN).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module mips_arb_picker
    import mips_cache_pkg::*;
#(
    parameter int NUM_RD = ARB_NUM_RD,
    parameter int IDX_W  = idx_width(NUM_RD)
) (
    input  logic [NUM_RD-1:0] req,
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]  ptr,
`endif
    output logic [NUM_RD-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    // Scan offsets from the top down so the port closest to ptr wins last.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = NUM_RD - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_RD;
            if (req[j]) begin
                idx = IDX_W'(j);
                any = 1'b1;
            end
        end
    end
`else
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end
`endif

    assign grant = any ? (NUM_RD'(1) << idx) : '0;

endmodule

// File: rtl/mips_cache_arbiter.sv
// Merges NUM_RD read-fill ports and the write-buffer drain onto one Avalon-MM master (round-robin reads with MIPS_ARB_ROUND_ROBIN_EN).
// Latency: read ack 2 cycles after request plus one per waitrequest cycle; one IDLE cycle between transfers.
// Backpressure: Avalon waitrequest stalls the FSM with address/data held; starvation limit forces write-buffer drains.
module mips_cache_arbiter
    import mips_cache_pkg::*;
#(
    parameter int NUM_RD       = ARB_NUM_RD,
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wb_valid,
    input  logic                     wb_full,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [DATA_W/8-1:0]      wb_be,
    output logic                     wb_pop,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [DATA_W-1:0]        mem_writedata,
    output logic [DATA_W/8-1:0]      mem_byteenable,
    input  logic                     waitrequest,
    input  logic [DATA_W-1:0]        mem_readdata,
    output logic                     busy
);

    localparam int IDX_W = idx_width(NUM_RD);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          state;
    logic [ADDR_W-1:0]   addr_q;
    logic [NUM_RD-1:0]   gnt_q;
    logic [CNT_W-1:0]    starve;
    logic                starve_hit;
    logic [NUM_RD-1:0]   req_masked;
    logic [NUM_RD-1:0]   pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   pick_addr;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]    ptr;
`endif

    // A port acked this cycle still has rd_req high; keep it out of the next grant.
    assign req_masked = rd_req & ~rd_ack;
    assign starve_hit = (starve == CNT_W'(STARVE_LIMIT));

    mips_arb_picker #(
        .NUM_RD (NUM_RD),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req   (req_masked),
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        .ptr   (ptr),
`endif
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (pick_idx == IDX_W'(i)) pick_addr = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_ack    <= '0;
            rd_data   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            addr_q    <= '0;
            gnt_q     <= '0;
            starve    <= '0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            ptr       <= '0;
`endif
        end else begin
            rd_ack <= '0;
            case (state)
                IDLE: begin
                    if (wb_valid && (wb_full || starve_hit)) begin
                        state     <= WRITE;
                        mem_write <= 1'b1;
                    end else if (pick_any) begin
                        state    <= READ;
                        mem_read <= 1'b1;
                        addr_q   <= pick_addr;
                        gnt_q    <= pick_grant;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
                        ptr      <= (pick_idx == IDX_W'(NUM_RD - 1)) ? '0 : pick_idx + 1'b1;
`endif
                    end else if (wb_valid) begin
                        state     <= WRITE;
                        mem_write <= 1'b1;
                    end
                end
                READ: begin
                    if (!waitrequest) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                        rd_ack   <= gnt_q;
                        rd_data  <= mem_readdata;
                        if (wb_valid && !starve_hit) starve <= starve + 1'b1;
                    end
                end
                WRITE: begin
                    if (!waitrequest) begin
                        state     <= IDLE;
                        mem_write <= 1'b0;
                        starve    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write beats come straight from the buffer head, which holds until popped.
    assign mem_address    = (state == WRITE) ? wb_addr : addr_q;
    assign mem_writedata  = (state == WRITE) ? wb_data : '0;
    assign mem_byteenable = (state == WRITE) ? wb_be   : '0;
    assign wb_pop         = (state == WRITE) && !waitrequest;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mips_cache_arbiter.sv
// Scoreboard bench for mips_cache_arbiter: transaction-level reference model, randomized requesters/write buffer/memory.
module tb_mips_cache_arbiter;

    localparam int NUM_RD       = 2;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int BE_W         = DATA_W / 8;
    localparam int STARVE_LIMIT = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_ack;
    logic [DATA_W-1:0]        rd_data;
    logic                     wb_valid, wb_full, wb_pop;
    logic [ADDR_W-1:0]        wb_addr, mem_address;
    logic [DATA_W-1:0]        wb_data, mem_writedata, mem_readdata;
    logic [BE_W-1:0]          wb_be, mem_byteenable;
    logic                     mem_read, mem_write, waitrequest, busy;

    mips_cache_arbiter #(
        .NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .wb_valid(wb_valid), .wb_full(wb_full), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_be(wb_be), .wb_pop(wb_pop), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .waitrequest(waitrequest),
        .mem_readdata(mem_readdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              kind;   // 1 = read, 2 = write
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } bus_t;
    typedef struct {
        int              port;
        logic [DATA_W-1:0] data;
    } ack_t;

    bus_t exp_bus[$];
    ack_t exp_ack[$];
    bus_t wbq[$];

    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 0;
    bit popped_q = 0;
    int pop_cnt  = 0;
    int rd_cycles = 0;

    // Reference model state: current bus transaction, starvation count, mask, rr pointer.
    int m_kind = 0;
    int m_port = 0;
    int m_starve = 0;
    int m_masked = -1;
    int m_ptr = 0;
    bit m_ack_due = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : ref_model
        int  p, nm;
        bit  do_wr;
        if (rst) begin
            m_kind = 0; m_starve = 0; m_ptr = 0; m_masked = -1; m_ack_due = 0;
            exp_bus.delete();
            exp_ack.delete();
        end else begin
            nm = -1;
            m_ack_due = 0;
            if (m_kind == 0) begin
                p = -1;
                do_wr = wb_valid && (wb_full || m_starve == STARVE_LIMIT);
                if (!do_wr) begin
                    for (int k = 0; k < NUM_RD; k++) begin
                        int c;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
                        c = (m_ptr + k) % NUM_RD;
`else
                        c = k;
`endif
                        if (p < 0 && rd_req[c] && c != m_masked) p = c;
                    end
                    if (p < 0 && wb_valid) do_wr = 1;
                end
                if (do_wr) begin
                    m_kind = 2;
                    exp_bus.push_back('{2, wb_addr, wb_data, wb_be});
                end else if (p >= 0) begin
                    m_kind = 1;
                    m_port = p;
                    m_ptr  = (p + 1) % NUM_RD;
                    exp_bus.push_back('{1, rd_addr[p*ADDR_W +: ADDR_W], '0, '0});
                end
            end else if (m_kind == 1) begin
                if (!waitrequest) begin
                    exp_ack.push_back('{m_port, mem_readdata});
                    if (wb_valid && m_starve < STARVE_LIMIT) m_starve++;
                    nm = m_port;
                    m_ack_due = 1;
                    m_kind = 0;
                end
            end else if (!waitrequest) begin
                m_kind = 0;
                m_starve = 0;
            end
            m_masked = nm;
        end
    end

    always @(negedge clk) begin : monitor
        bus_t b;
        ack_t a;
        popped_q = wb_pop;
        if (mon_en) begin
            if (wb_pop) pop_cnt++;
            if (mem_read) rd_cycles++;
            chk("strobes", {busy, mem_read, mem_write}, {m_kind != 0, m_kind == 1, m_kind == 2});
            chk("wb_pop", wb_pop, (m_kind == 2) && !waitrequest);
            chk("ack_pulse", rd_ack != 0, m_ack_due);
            if (mem_read || mem_write) begin
                chk("bus_queue", exp_bus.size() != 0, 1'b1);
                if (exp_bus.size() != 0) begin
                    b = exp_bus[0];
                    chk("bus_kind", mem_write ? 2 : 1, b.kind);
                    chk("bus_addr", mem_address, b.addr);
                    if (mem_write) begin
                        chk("wr_data", mem_writedata, b.data);
                        chk("wr_be", mem_byteenable, b.be);
                    end
                    if (!waitrequest) void'(exp_bus.pop_front());
                end
            end
            if (rd_ack != 0) begin
                chk("ack_queue", exp_ack.size() != 0, 1'b1);
                if (exp_ack.size() != 0) begin
                    a = exp_ack.pop_front();
                    chk("ack_port", rd_ack, 64'(1) << a.port);
                    chk("rd_data", rd_data, a.data);
                end
            end
        end
    end

    // One cycle of randomized stimulus: requesters, write buffer, memory.
    task automatic step(input int p_req, input int p_wait, input int p_push, input int depth);
        if (popped_q && wbq.size() > 0) void'(wbq.pop_front());
        popped_q = 0;
        if (wbq.size() < depth && $urandom_range(99) < p_push)
            wbq.push_back('{2, $urandom, $urandom, BE_W'($urandom)});
        wb_valid = wbq.size() > 0;
        wb_full  = wbq.size() >= depth;
        wb_addr  = wb_valid ? wbq[0].addr : '0;
        wb_data  = wb_valid ? wbq[0].data : '0;
        wb_be    = wb_valid ? wbq[0].be   : '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_req[i]) begin
                if (rd_ack[i]) begin
                    if ($urandom_range(99) >= p_req) rd_req[i] = 1'b0;
                    rd_addr[i*ADDR_W +: ADDR_W] = $urandom;
                end
            end else if ($urandom_range(99) < p_req) begin
                rd_req[i] = 1'b1;
                rd_addr[i*ADDR_W +: ADDR_W] = $urandom;
            end
        end
        waitrequest  = $urandom_range(99) < p_wait;
        mem_readdata = $urandom;
    endtask

    task automatic run(input int n, input int p_req, input int p_wait, input int p_push, input int depth);
        repeat (n) begin
            @(posedge clk); #1;
            step(p_req, p_wait, p_push, depth);
        end
    endtask

    initial begin : stim
        bit found;
        rst = 1'b1; rd_req = '0; rd_addr = '0; wb_valid = 0; wb_full = 0;
        wb_addr = '0; wb_data = '0; wb_be = '0; waitrequest = 1'b0; mem_readdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_be", mem_byteenable, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ack", rd_ack, 0);

        // Single read on port 1 with two waitrequest cycles.
        @(posedge clk); #1;
        rd_req = 2'b10;
        rd_addr[ADDR_W +: ADDR_W] = 32'h0000_1000;
        waitrequest = 1'b1;
        mem_readdata = 32'hDEAD_BEEF;
        rd_cycles = 0;
        repeat (3) @(posedge clk);
        #1 waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("single_rd_len", rd_cycles, 3);
        chk("single_ack", rd_ack, 2'b10);
        chk("single_data", rd_data, 32'hDEAD_BEEF);
        rd_req = '0;

        run(800, 30, 30, 20, 4);
        pop_cnt = 0;
        run(600, 100, 10, 10, 16);
        chk("starve_write", pop_cnt > 0, 1'b1);
        run(400, 50, 25, 80, 2);

        // Reset in the middle of a stalled read.
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(posedge clk); #1;
            step(60, 0, 30, 4);
            if (m_kind == 1) begin
                found = 1;
                waitrequest = 1'b1;
            end
        end
        chk("rst_setup", found, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_read", mem_read, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", rd_ack, 0);
        chk("midrst_pop", wb_pop, 0);

        run(400, 40, 30, 30, 4);

        found = 0;
        for (int t = 0; t < 600 && !found; t++) begin
            @(posedge clk); #1;
            step(0, 20, 0, 16);
            if (m_kind == 0 && rd_req == 0 && wbq.size() == 0 && !m_ack_due) found = 1;
        end
        chk("drain", found, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("bus_left", exp_bus.size(), 0);
        chk("ack_left", exp_ack.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
